// File: rtl/axi_lite_reg_responder.sv
// AXI4-Lite subordinate terminating all five channels into a flat register bank.
// Optional per-byte write strobes are enabled by defining AXI_LITE_REG_WSTRB_EN.
module axi_lite_reg_responder #(
   parameter int unsigned          AddrWidth = 32,
   parameter int unsigned          DataWidth = 32,
   parameter int unsigned          NumRegs   = 16,
   parameter logic [AddrWidth-1:0] BaseAddr  = AddrWidth'(0)
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic [AddrWidth-1:0]           aw_addr_i,
   input  logic [2:0]                     aw_prot_i,
   input  logic                           aw_valid_i,
   output logic                           aw_ready_o,
   input  logic [DataWidth-1:0]           w_data_i,
   input  logic [DataWidth/8-1:0]         w_strb_i,
   input  logic                           w_valid_i,
   output logic                           w_ready_o,
   output logic [1:0]                     b_resp_o,
   output logic                           b_valid_o,
   input  logic                           b_ready_i,
   input  logic [AddrWidth-1:0]           ar_addr_i,
   input  logic [2:0]                     ar_prot_i,
   input  logic                           ar_valid_i,
   output logic                           ar_ready_o,
   output logic [DataWidth-1:0]           r_data_o,
   output logic [1:0]                     r_resp_o,
   output logic                           r_valid_o,
   input  logic                           r_ready_i,
   output logic [NumRegs*DataWidth-1:0]   reg_q_o
);

   localparam int unsigned StrbWidth = DataWidth / 8;
   localparam int unsigned OffBits   = $clog2(StrbWidth);
   localparam logic [1:0]  RespOkay  = 2'b00;
   localparam logic [1:0]  RespSlv   = 2'b10;

   function automatic logic [AddrWidth-1:0] addr_index(input logic [AddrWidth-1:0] addr);
      return (addr - BaseAddr) >> OffBits;
   endfunction

   function automatic logic addr_in_range(input logic [AddrWidth-1:0] addr);
      return (addr >= BaseAddr) && (addr_index(addr) < AddrWidth'(NumRegs));
   endfunction

`ifdef AXI_LITE_REG_WSTRB_EN
   function automatic logic [DataWidth-1:0] strb_merge(input logic [DataWidth-1:0] old_val,
                                                       input logic [DataWidth-1:0] new_val,
                                                       input logic [StrbWidth-1:0] strb);
      logic [DataWidth-1:0] res;
      res = old_val;
      for (int k = 0; k < StrbWidth; k++) begin
         if (strb[k]) begin
            res[8*k +: 8] = new_val[8*k +: 8];
         end else begin
            res[8*k +: 8] = old_val[8*k +: 8];
         end
      end
      return res;
   endfunction
`endif

   logic                 aw_held_q, aw_held_d;
   logic [AddrWidth-1:0] aw_addr_q, aw_addr_d;
   logic                 w_held_q, w_held_d;
   logic [DataWidth-1:0] w_data_q, w_data_d;
`ifdef AXI_LITE_REG_WSTRB_EN
   logic [StrbWidth-1:0] w_strb_q, w_strb_d;
   logic [StrbWidth-1:0] wr_strb_s;
`endif
   logic                 b_valid_q, b_valid_d;
   logic [1:0]           b_resp_q, b_resp_d;
   logic                 r_valid_q, r_valid_d;
   logic [DataWidth-1:0] r_data_q, r_data_d;
   logic [1:0]           r_resp_q, r_resp_d;
   logic [DataWidth-1:0] regs_q [NumRegs];
   logic [DataWidth-1:0] regs_d [NumRegs];

   logic                 aw_hs_s, w_hs_s, ar_hs_s, commit_s;
   logic [AddrWidth-1:0] wr_addr_s, wr_idx_s, rd_idx_s;
   logic [DataWidth-1:0] wr_data_s, rd_data_s;
   logic                 wr_ok_s, rd_ok_s;
   logic                 unused_ok_s;

`ifdef AXI_LITE_REG_WSTRB_EN
   assign unused_ok_s = ^{aw_prot_i, ar_prot_i};
   assign wr_strb_s   = w_held_q ? w_strb_q : w_strb_i;
`else
   assign unused_ok_s = ^{aw_prot_i, ar_prot_i, w_strb_i};
`endif

   // Readies depend on state only so they never combinationally follow the valids.
   assign aw_ready_o = !aw_held_q && !b_valid_q;
   assign w_ready_o  = !w_held_q && !b_valid_q;
   assign ar_ready_o = !r_valid_q;

   assign aw_hs_s   = aw_valid_i && aw_ready_o;
   assign w_hs_s    = w_valid_i && w_ready_o;
   assign ar_hs_s   = ar_valid_i && ar_ready_o;
   assign commit_s  = (aw_held_q || aw_hs_s) && (w_held_q || w_hs_s);
   assign wr_addr_s = aw_held_q ? aw_addr_q : aw_addr_i;
   assign wr_data_s = w_held_q ? w_data_q : w_data_i;
   assign wr_idx_s  = addr_index(wr_addr_s);
   assign wr_ok_s   = addr_in_range(wr_addr_s);
   assign rd_idx_s  = addr_index(ar_addr_i);
   assign rd_ok_s   = addr_in_range(ar_addr_i);

   assign b_valid_o = b_valid_q;
   assign b_resp_o  = b_resp_q;
   assign r_valid_o = r_valid_q;
   assign r_data_o  = r_data_q;
   assign r_resp_o  = r_resp_q;

   for (genvar gi = 0; gi < NumRegs; gi++) begin : g_flat
      assign reg_q_o[gi*DataWidth +: DataWidth] = regs_q[gi];
   end

   // Write channel holding, commit and B response.
   always_comb begin
      aw_addr_d = aw_addr_q;
      w_data_d  = w_data_q;
`ifdef AXI_LITE_REG_WSTRB_EN
      w_strb_d  = w_strb_q;
`endif
      aw_held_d = aw_held_q;
      w_held_d  = w_held_q;
      b_valid_d = b_valid_q;
      b_resp_d  = b_resp_q;
      if (aw_hs_s) begin
         aw_addr_d = aw_addr_i;
      end else begin
         aw_addr_d = aw_addr_q;
      end
      if (w_hs_s) begin
         w_data_d = w_data_i;
`ifdef AXI_LITE_REG_WSTRB_EN
         w_strb_d = w_strb_i;
`endif
      end else begin
         w_data_d = w_data_q;
      end
      if (commit_s) begin
         aw_held_d = 1'b0;
         w_held_d  = 1'b0;
         b_valid_d = 1'b1;
         b_resp_d  = wr_ok_s ? RespOkay : RespSlv;
      end else begin
         aw_held_d = aw_held_q || aw_hs_s;
         w_held_d  = w_held_q || w_hs_s;
         if (b_valid_q && b_ready_i) begin
            b_valid_d = 1'b0;
         end else begin
            b_valid_d = b_valid_q;
         end
      end
   end

   // Register bank update; only the decoded in-range register changes at commit.
   always_comb begin
      for (int i = 0; i < NumRegs; i++) begin
         regs_d[i] = regs_q[i];
         if (commit_s && wr_ok_s && (wr_idx_s == AddrWidth'(i))) begin
`ifdef AXI_LITE_REG_WSTRB_EN
            regs_d[i] = strb_merge(regs_q[i], wr_data_s, wr_strb_s);
`else
            regs_d[i] = wr_data_s;
`endif
         end else begin
            regs_d[i] = regs_q[i];
         end
      end
   end

   // Read mux uses the pre-commit bank, so a same-edge read sees the old value.
   always_comb begin
      rd_data_s = {DataWidth{1'b0}};
      for (int i = 0; i < NumRegs; i++) begin
         if (rd_idx_s == AddrWidth'(i)) begin
            rd_data_s = regs_q[i];
         end else begin
            rd_data_s = rd_data_s;
         end
      end
      r_valid_d = r_valid_q;
      r_data_d  = r_data_q;
      r_resp_d  = r_resp_q;
      if (ar_hs_s) begin
         r_valid_d = 1'b1;
         r_data_d  = rd_ok_s ? rd_data_s : {DataWidth{1'b0}};
         r_resp_d  = rd_ok_s ? RespOkay : RespSlv;
      end else if (r_valid_q && r_ready_i) begin
         r_valid_d = 1'b0;
      end else begin
         r_valid_d = r_valid_q;
      end
   end

   // State registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         aw_held_q <= 1'b0;
         aw_addr_q <= {AddrWidth{1'b0}};
         w_held_q  <= 1'b0;
         w_data_q  <= {DataWidth{1'b0}};
`ifdef AXI_LITE_REG_WSTRB_EN
         w_strb_q  <= {StrbWidth{1'b0}};
`endif
         b_valid_q <= 1'b0;
         b_resp_q  <= 2'b00;
         r_valid_q <= 1'b0;
         r_data_q  <= {DataWidth{1'b0}};
         r_resp_q  <= 2'b00;
         for (int i = 0; i < NumRegs; i++) begin
            regs_q[i] <= {DataWidth{1'b0}};
         end
      end else begin
         aw_held_q <= aw_held_d;
         aw_addr_q <= aw_addr_d;
         w_held_q  <= w_held_d;
         w_data_q  <= w_data_d;
`ifdef AXI_LITE_REG_WSTRB_EN
         w_strb_q  <= w_strb_d;
`endif
         b_valid_q <= b_valid_d;
         b_resp_q  <= b_resp_d;
         r_valid_q <= r_valid_d;
         r_data_q  <= r_data_d;
         r_resp_q  <= r_resp_d;
         for (int i = 0; i < NumRegs; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

endmodule

// File: tb/tb_axi_lite_reg_responder.sv
// Scoreboard bench for axi_lite_reg_responder with default parameters (32-bit, 16 registers).
module tb_axi_lite_reg_responder;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic [31:0]   aw_addr_i;
   logic [2:0]    aw_prot_i;
   logic          aw_valid_i;
   logic          aw_ready_o;
   logic [31:0]   w_data_i;
   logic [3:0]    w_strb_i;
   logic          w_valid_i;
   logic          w_ready_o;
   logic [1:0]    b_resp_o;
   logic          b_valid_o;
   logic          b_ready_i;
   logic [31:0]   ar_addr_i;
   logic [2:0]    ar_prot_i;
   logic          ar_valid_i;
   logic          ar_ready_o;
   logic [31:0]   r_data_o;
   logic [1:0]    r_resp_o;
   logic          r_valid_o;
   logic          r_ready_i;
   logic [511:0]  reg_q_o;

   typedef struct {
      logic [31:0] data;
      logic [1:0]  resp;
   } r_exp_t;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [1:0]  exp_b[$];
   r_exp_t      exp_r[$];
   logic [31:0] mdl [16];

   axi_lite_reg_responder dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .aw_addr_i(aw_addr_i), .aw_prot_i(aw_prot_i), .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o),
      .w_data_i(w_data_i), .w_strb_i(w_strb_i), .w_valid_i(w_valid_i), .w_ready_o(w_ready_o),
      .b_resp_o(b_resp_o), .b_valid_o(b_valid_o), .b_ready_i(b_ready_i),
      .ar_addr_i(ar_addr_i), .ar_prot_i(ar_prot_i), .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o),
      .r_data_o(r_data_o), .r_resp_o(r_resp_o), .r_valid_o(r_valid_o), .r_ready_i(r_ready_i),
      .reg_q_o(reg_q_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] reg_of(input int i);
      return reg_q_o[i*32 +: 32];
   endfunction

   function automatic logic [31:0] mdl_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                             input logic [3:0] strb);
      logic [31:0] res;
      res = new_v;
`ifdef AXI_LITE_REG_WSTRB_EN
      for (int k = 0; k < 4; k++) begin
         res[8*k +: 8] = strb[k] ? new_v[8*k +: 8] : old_v[8*k +: 8];
      end
`endif
      return res;
   endfunction

   // Scoreboard monitor: pops an expectation on every B/R handshake.
   always begin
      @(negedge clk_i);
      #2;
      if (rst_ni && b_valid_o && b_ready_i) begin
         if (exp_b.size() == 0) begin
            check_val("b_unexpected", 64'(b_valid_o), 64'd0);
         end else begin
            check_val("b_resp", 64'(b_resp_o), 64'(exp_b.pop_front()));
         end
      end
      if (rst_ni && r_valid_o && r_ready_i) begin
         if (exp_r.size() == 0) begin
            check_val("r_unexpected", 64'(r_valid_o), 64'd0);
         end else begin
            r_exp_t e;
            e = exp_r.pop_front();
            check_val("r_data", 64'(r_data_o), 64'(e.data));
            check_val("r_resp", 64'(r_resp_o), 64'(e.resp));
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk_i);
   endtask

   task automatic send_aw(input logic [31:0] addr);
      int n = 0;
      aw_addr_i  = addr;
      aw_valid_i = 1'b1;
      while (!aw_ready_o && n < 20) begin
         @(negedge clk_i);
         n++;
      end
      if (!aw_ready_o) check_val("aw_timeout", 64'(aw_ready_o), 64'd1);
      @(negedge clk_i);
      aw_valid_i = 1'b0;
   endtask

   task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
      int n = 0;
      w_data_i  = data;
      w_strb_i  = strb;
      w_valid_i = 1'b1;
      while (!w_ready_o && n < 20) begin
         @(negedge clk_i);
         n++;
      end
      if (!w_ready_o) check_val("w_timeout", 64'(w_ready_o), 64'd1);
      @(negedge clk_i);
      w_valid_i = 1'b0;
   endtask

   task automatic send_ar(input logic [31:0] addr);
      int n = 0;
      ar_addr_i  = addr;
      ar_valid_i = 1'b1;
      while (!ar_ready_o && n < 20) begin
         @(negedge clk_i);
         n++;
      end
      if (!ar_ready_o) check_val("ar_timeout", 64'(ar_ready_o), 64'd1);
      @(negedge clk_i);
      ar_valid_i = 1'b0;
   endtask

   task automatic expect_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
      if (addr < 32'h40) begin
         exp_b.push_back(2'b00);
         mdl[addr >> 2] = mdl_merge(mdl[addr >> 2], data, strb);
      end else begin
         exp_b.push_back(2'b10);
      end
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
      expect_write(addr, data, strb);
      fork
         send_aw(addr);
         send_w(data, strb);
      join
   endtask

   task automatic rd(input logic [31:0] addr);
      r_exp_t e;
      e.data = (addr < 32'h40) ? mdl[addr >> 2] : 32'h0;
      e.resp = (addr < 32'h40) ? 2'b00 : 2'b10;
      exp_r.push_back(e);
      send_ar(addr);
   endtask

   task automatic check_bank(input string tag);
      for (int i = 0; i < 16; i++) check_val(tag, 64'(reg_of(i)), 64'(mdl[i]));
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
      rst_ni = 1'b0;
      aw_addr_i = 32'h0; aw_prot_i = 3'b000; aw_valid_i = 1'b0;
      w_data_i = 32'h0; w_strb_i = 4'h0; w_valid_i = 1'b0;
      ar_addr_i = 32'h0; ar_prot_i = 3'b000; ar_valid_i = 1'b0;
      b_ready_i = 1'b1; r_ready_i = 1'b1;
      idle(2);
      check_val("rst_b_valid", 64'(b_valid_o), 64'd0);
      check_val("rst_r_valid", 64'(r_valid_o), 64'd0);
      check_val("rst_readies", 64'({aw_ready_o, w_ready_o, ar_ready_o}), 64'd7);
      check_val("rst_r_data", 64'(r_data_o), 64'd0);
      check_bank("rst_bank");
      rst_ni = 1'b1;
      idle(1);

      // AW and W together, B the very next cycle.
      wr(32'h8, 32'hDEADBEEF, 4'hF);
      check_val("b_latency", 64'(b_valid_o), 64'd1);
      idle(1);
      check_val("reg2", 64'(reg_of(2)), 64'hDEADBEEF);

      // W before AW, then a stalled B.
      b_ready_i = 1'b0;
      expect_write(32'h4, 32'h12345678, 4'hF);
      send_w(32'h12345678, 4'hF);
      check_val("w_only_no_b", 64'(b_valid_o), 64'd0);
      send_aw(32'h4);
      for (int k = 0; k < 3; k++) begin
         check_val("stall_b_valid", 64'(b_valid_o), 64'd1);
         check_val("stall_b_resp", 64'(b_resp_o), 64'd0);
         check_val("stall_readies", 64'({aw_ready_o, w_ready_o}), 64'd0);
         @(negedge clk_i);
      end
      b_ready_i = 1'b1;
      idle(1);
      check_val("b_cleared", 64'(b_valid_o), 64'd0);
      check_val("reg1", 64'(reg_of(1)), 64'h12345678);

      // Read with a stalled R channel.
      r_ready_i = 1'b0;
      rd(32'h8);
      for (int k = 0; k < 4; k++) begin
         check_val("rstall_valid", 64'(r_valid_o), 64'd1);
         check_val("rstall_data", 64'(r_data_o), 64'hDEADBEEF);
         check_val("rstall_ar_ready", 64'(ar_ready_o), 64'd0);
         @(negedge clk_i);
      end
      r_ready_i = 1'b1;
      idle(1);
      check_val("ar_ready_back", 64'(ar_ready_o), 64'd1);

      // Out of range accesses.
      wr(32'h40, 32'hCAFEF00D, 4'hF);
      idle(2);
      check_bank("oor_bank");
      rd(32'h40);
      idle(2);

      // Same-edge read and commit to register 3.
      begin
         r_exp_t e;
         e.data = mdl[3];
         e.resp = 2'b00;
         exp_r.push_back(e);
      end
      expect_write(32'hC, 32'hA5A5A5A5, 4'hF);
      fork
         send_aw(32'hC);
         send_w(32'hA5A5A5A5, 4'hF);
         send_ar(32'hC);
      join
      idle(2);
      rd(32'hC);
      idle(2);

      // Strobed writes.
      wr(32'h0, 32'h11223344, 4'hF);
      idle(2);
      wr(32'h0, 32'hFFFFFFFF, 4'h5);
      idle(2);
`ifdef AXI_LITE_REG_WSTRB_EN
      check_val("strb_5", 64'(reg_of(0)), 64'h11FF33FF);
`else
      check_val("strb_5", 64'(reg_of(0)), 64'hFFFFFFFF);
`endif
      wr(32'h0, 32'hAAAAAAAA, 4'h0);
      idle(2);
      check_val("strb_0", 64'(reg_of(0)), 64'(mdl[0]));
      rd(32'h0);
      idle(2);

      // Reset with AW held and an R pending.
      r_ready_i  = 1'b0;
      aw_addr_i  = 32'h10;
      aw_valid_i = 1'b1;
      ar_addr_i  = 32'h4;
      ar_valid_i = 1'b1;
      @(negedge clk_i);
      aw_valid_i = 1'b0;
      ar_valid_i = 1'b0;
      check_val("held_aw_ready", 64'(aw_ready_o), 64'd0);
      check_val("held_r_valid", 64'(r_valid_o), 64'd1);
      rst_ni = 1'b0;
      #1;
      for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
      check_bank("mid_rst_bank");
      check_val("mid_rst_valids", 64'({b_valid_o, r_valid_o}), 64'd0);
      check_val("mid_rst_r_data", 64'(r_data_o), 64'd0);
      check_val("mid_rst_readies", 64'({aw_ready_o, w_ready_o, ar_ready_o}), 64'd7);
      r_ready_i = 1'b1;
      @(negedge clk_i);
      rst_ni = 1'b1;
      idle(1);
      send_w(32'h55AA55AA, 4'hF);
      idle(1);
      check_val("post_rst_no_commit", 64'(b_valid_o), 64'd0);
      exp_b.push_back(2'b00);
      mdl[4] = 32'h55AA55AA;
      send_aw(32'h10);
      idle(2);
      check_val("reg4", 64'(reg_of(4)), 64'h55AA55AA);

      idle(2);
      check_bank("final_bank");
      check_val("b_drain", 64'(exp_b.size()), 64'd0);
      check_val("r_drain", 64'(exp_r.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
